// File: rtl/led_fade_driver.sv
// PWM LED driver: each channel ramps its brightness toward the on/off target
// word in discrete steps, or snaps to full on/off when fading is disabled.
module led_fade_driver #(
    parameter int NUM_LEDS   = 18,
    parameter int LEVEL_BITS = 4,
    parameter int FADE_DIV   = 781250
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_LEDS-1:0] led_target,
    input  logic                fade_enable,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                busy
);

    // A one-bit counter that sits at zero gives a tick every cycle when FADE_DIV is 1.
    localparam int FC_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [LEVEL_BITS-1:0] LVL_MAX = {LEVEL_BITS{1'b1}};
    localparam logic [LEVEL_BITS-1:0] LVL_MIN = {LEVEL_BITS{1'b0}};
    localparam logic [FC_W-1:0]       FC_LAST = FC_W'(FADE_DIV - 1);

    logic [LEVEL_BITS-1:0] r_pwm_cnt;
    logic [FC_W-1:0]       r_fade_cnt;
    logic [LEVEL_BITS-1:0] r_level     [NUM_LEDS];
    logic [LEVEL_BITS-1:0] w_level_nxt [NUM_LEDS];
    logic [NUM_LEDS-1:0]   w_pwm_on;
    logic [NUM_LEDS-1:0]   w_off_target;
    logic                  w_tick;

    // Brightness step strobe
    always_comb begin
        w_tick = (r_fade_cnt == FC_LAST);
    end

    // Free-running PWM phase and fade-step divider
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pwm_cnt  <= LVL_MIN;
            r_fade_cnt <= {FC_W{1'b0}};
        end else begin
            r_pwm_cnt <= r_pwm_cnt + LEVEL_BITS'(1);
            if (w_tick) begin
                r_fade_cnt <= {FC_W{1'b0}};
            end else begin
                r_fade_cnt <= r_fade_cnt + FC_W'(1);
            end
        end
    end

    // Next brightness per channel: snap when fading is off, else saturating step on tick
    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            w_level_nxt[i] = r_level[i];
            if (!fade_enable) begin
                w_level_nxt[i] = led_target[i] ? LVL_MAX : LVL_MIN;
            end else if (w_tick && led_target[i] && (r_level[i] != LVL_MAX)) begin
                w_level_nxt[i] = r_level[i] + LEVEL_BITS'(1);
            end else if (w_tick && !led_target[i] && (r_level[i] != LVL_MIN)) begin
                w_level_nxt[i] = r_level[i] - LEVEL_BITS'(1);
            end else begin
                w_level_nxt[i] = r_level[i];
            end
        end
    end

    // Brightness level registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_level[i] <= LVL_MIN;
            end
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_level[i] <= w_level_nxt[i];
            end
        end
    end

    // PWM compare; full level forces the pin solidly on
    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            w_pwm_on[i]     = (r_level[i] == LVL_MAX) || (r_level[i] > r_pwm_cnt);
            w_off_target[i] = (r_level[i] != (led_target[i] ? LVL_MAX : LVL_MIN));
        end
    end

    // Registered pin drive
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_out <= {NUM_LEDS{1'b0}};
        end else begin
            led_out <= w_pwm_on;
        end
    end

    // Any channel still away from its endpoint
    always_comb begin
        busy = |w_off_target;
    end

endmodule
